// File: rtl/fx_ram_bridge_if.sv
// Signal bundle between the CPU RAM port, the bridge and the 16-bit memory controller.
// The slave modport is the bridge's view; master is the environment (CPU + controller).
interface fx_ram_bridge_if #(
  parameter int AW = 21
);
  logic          CE;
  logic          BCYSTn;
  logic [AW-1:0] RAM_A;
  logic [31:0]   RAM_DI;
  logic [31:0]   RAM_DO;
  logic          RAM_CEn;
  logic          RAM_WEn;
  logic [3:0]    RAM_BEn;
  logic          RAM_READYn;
  logic [AW-2:0] MEM_ADDR;
  logic [15:0]   MEM_DIN;
  logic [15:0]   MEM_DOUT;
  logic [1:0]    MEM_BE;
  logic          MEM_WE;
  logic          MEM_REQ;
  logic          MEM_ACK;

  modport slave (
    input  CE, BCYSTn, RAM_A, RAM_DI, RAM_CEn, RAM_WEn, RAM_BEn, MEM_DOUT, MEM_ACK,
    output RAM_DO, RAM_READYn, MEM_ADDR, MEM_DIN, MEM_BE, MEM_WE, MEM_REQ
  );

  modport master (
    output CE, BCYSTn, RAM_A, RAM_DI, RAM_CEn, RAM_WEn, RAM_BEn, MEM_DOUT, MEM_ACK,
    input  RAM_DO, RAM_READYn, MEM_ADDR, MEM_DIN, MEM_BE, MEM_WE, MEM_REQ
  );
endinterface

// File: rtl/fx_ram_bridge.sv
// Splits a 32-bit CPU RAM cycle into up to two 16-bit req/ack transactions
// (low half first), holding RAM_READYn high until every needed half completes.
module fx_ram_bridge #(
  parameter int AW = 21
) (
  input logic             CLK,
  input logic             RESn,
  fx_ram_bridge_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    GAP  = 3'd2,
    HI   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t         state_r, state_n;
  logic [AW-3:0]  a_r, a_n;
  logic [15:0]    di_hi_r, di_hi_n;
  logic [1:0]     ben_hi_r, ben_hi_n;
  logic           wen_r, wen_n;
  logic           need_hi_r, need_hi_n;
  logic           mem_req_r, mem_req_n;
  logic [AW-2:0]  mem_addr_r, mem_addr_n;
  logic [1:0]     mem_be_r, mem_be_n;
  logic [15:0]    mem_din_r, mem_din_n;
  logic           mem_we_r, mem_we_n;
  logic [31:0]    ram_do_r, ram_do_n;
  logic           start_s;

  // Overwrite only the byte lanes whose enable is set.
  function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                          input logic [15:0] new_v,
                                          input logic [1:0]  be);
    return {be[1] ? new_v[15:8] : old_v[15:8],
            be[0] ? new_v[7:0]  : old_v[7:0]};
  endfunction

  function automatic logic [31:0] clear_lanes(input logic [31:0] d, input logic [3:0] ben);
    return {ben[3] ? 8'h00 : d[31:24], ben[2] ? 8'h00 : d[23:16],
            ben[1] ? 8'h00 : d[15:8],  ben[0] ? 8'h00 : d[7:0]};
  endfunction

  assign start_s = bus.CE && !bus.BCYSTn && !bus.RAM_CEn;

  // Next-state and next-register computation for the transaction sequencer.
  always_comb begin
    state_n    = state_r;
    a_n        = a_r;
    di_hi_n    = di_hi_r;
    ben_hi_n   = ben_hi_r;
    wen_n      = wen_r;
    need_hi_n  = need_hi_r;
    mem_req_n  = mem_req_r;
    mem_addr_n = mem_addr_r;
    mem_be_n   = mem_be_r;
    mem_din_n  = mem_din_r;
    mem_we_n   = mem_we_r;
    ram_do_n   = ram_do_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          a_n       = bus.RAM_A[AW-1:2];
          di_hi_n   = bus.RAM_DI[31:16];
          ben_hi_n  = bus.RAM_BEn[3:2];
          wen_n     = bus.RAM_WEn;
          need_hi_n = (bus.RAM_BEn[3:2] != 2'b11);
          ram_do_n  = clear_lanes(ram_do_r, bus.RAM_BEn);
          // Request fields are loaded straight from the bus so REQ rises on the latch edge.
          if (bus.RAM_BEn[1:0] != 2'b11) begin
            state_n    = LO;
            mem_req_n  = 1'b1;
            mem_addr_n = {bus.RAM_A[AW-1:2], 1'b0};
            mem_be_n   = ~bus.RAM_BEn[1:0];
            mem_din_n  = bus.RAM_DI[15:0];
            mem_we_n   = ~bus.RAM_WEn;
          end else if (bus.RAM_BEn[3:2] != 2'b11) begin
            state_n    = HI;
            mem_req_n  = 1'b1;
            mem_addr_n = {bus.RAM_A[AW-1:2], 1'b1};
            mem_be_n   = ~bus.RAM_BEn[3:2];
            mem_din_n  = bus.RAM_DI[31:16];
            mem_we_n   = ~bus.RAM_WEn;
          end else begin
            state_n = DONE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      LO: begin
        if (bus.MEM_ACK) begin
          mem_req_n = 1'b0;
          state_n   = need_hi_r ? GAP : DONE;
          if (wen_r) begin
            ram_do_n[15:0] = merge16(ram_do_r[15:0], bus.MEM_DOUT, mem_be_r);
          end else begin
            ram_do_n = ram_do_r;
          end
        end else begin
          state_n = LO;
        end
      end
      GAP: begin
        state_n    = HI;
        mem_req_n  = 1'b1;
        mem_addr_n = {a_r, 1'b1};
        mem_be_n   = ~ben_hi_r;
        mem_din_n  = di_hi_r;
        mem_we_n   = ~wen_r;
      end
      HI: begin
        if (bus.MEM_ACK) begin
          mem_req_n = 1'b0;
          state_n   = DONE;
          if (wen_r) begin
            ram_do_n[31:16] = merge16(ram_do_r[31:16], bus.MEM_DOUT, mem_be_r);
          end else begin
            ram_do_n = ram_do_r;
          end
        end else begin
          state_n = HI;
        end
      end
      DONE: begin
        if (bus.CE) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

  // State, latched CPU cycle and registered memory-side outputs.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_r    <= IDLE;
      a_r        <= '0;
      di_hi_r    <= 16'h0000;
      ben_hi_r   <= 2'b11;
      wen_r      <= 1'b1;
      need_hi_r  <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_addr_r <= '0;
      mem_be_r   <= 2'b00;
      mem_din_r  <= 16'h0000;
      mem_we_r   <= 1'b0;
      ram_do_r   <= 32'h0000_0000;
    end else begin
      state_r    <= state_n;
      a_r        <= a_n;
      di_hi_r    <= di_hi_n;
      ben_hi_r   <= ben_hi_n;
      wen_r      <= wen_n;
      need_hi_r  <= need_hi_n;
      mem_req_r  <= mem_req_n;
      mem_addr_r <= mem_addr_n;
      mem_be_r   <= mem_be_n;
      mem_din_r  <= mem_din_n;
      mem_we_r   <= mem_we_n;
      ram_do_r   <= ram_do_n;
    end
  end

  assign bus.RAM_DO     = ram_do_r;
  assign bus.RAM_READYn = (state_r != DONE);
  assign bus.MEM_REQ    = mem_req_r;
  assign bus.MEM_ADDR   = mem_addr_r;
  assign bus.MEM_BE     = mem_be_r;
  assign bus.MEM_DIN    = mem_din_r;
  assign bus.MEM_WE     = mem_we_r;

endmodule

// File: tb/tb_fx_ram_bridge.sv
// Bench for fx_ram_bridge: acts as CPU and memory controller, predicting the half-word
// transactions and the returned read word from byte enables with plain arithmetic.
module tb_fx_ram_bridge;
  localparam int AW = 21;

  logic CLK  = 1'b0;
  logic RESn = 1'b0;

  fx_ram_bridge_if #(.AW(AW)) bus ();
  fx_ram_bridge #(.AW(AW)) dut (.CLK(CLK), .RESn(RESn), .bus(bus));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-2:0] addr;
    logic [1:0]    be;
    logic [15:0]   din;
    logic          we;
    bit            hi;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] exp_do;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    bus.CE       = 1'b1;
    bus.BCYSTn   = 1'b1;
    bus.RAM_CEn  = 1'b1;
    bus.RAM_WEn  = 1'b1;
    bus.RAM_BEn  = 4'hF;
    bus.MEM_ACK  = 1'b0;
    bus.MEM_DOUT = 16'h0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, bus.MEM_REQ}, 32'd0);
    chk({tag, "_ready"}, {31'b0, bus.RAM_READYn}, 32'd1);
    chk({tag, "_addr"},  32'(bus.MEM_ADDR), 32'd0);
    chk({tag, "_be"},    32'(bus.MEM_BE), 32'd0);
    chk({tag, "_we"},    {31'b0, bus.MEM_WE}, 32'd0);
    chk({tag, "_din"},   32'(bus.MEM_DIN), 32'd0);
    chk({tag, "_do"},    bus.RAM_DO, 32'd0);
  endtask

  // One CPU cycle; dlo/dhi are the controller's read data for each half.
  task automatic bus_cycle(input logic [AW-1:0] a, input logic [31:0] di, input logic [3:0] ben,
                           input logic wen, input logic [15:0] dlo, input logic [15:0] dhi,
                           input int ce_div, input int ack_dly, input bit noise, input bit abort_hi);
    txn_t        t, cur;
    int          hw, dly, cnt;
    bit          in_txn, ack_sent, ready_low, ce_prev, done;
    logic [31:0] rd;
    exp_q.delete();
    hw = int'(a) / 4 * 2;
    if (ben[1:0] != 2'b11) begin
      t.addr = (AW-1)'(hw); t.be = ~ben[1:0]; t.din = di[15:0]; t.we = !wen; t.hi = 1'b0;
      exp_q.push_back(t);
    end
    if (ben[3:2] != 2'b11) begin
      t.addr = (AW-1)'(hw + 1); t.be = ~ben[3:2]; t.din = di[31:16]; t.we = !wen; t.hi = 1'b1;
      exp_q.push_back(t);
    end
    rd = {dhi, dlo};
    for (int b = 0; b < 4; b++) begin
      if (ben[b])   exp_do[8*b +: 8] = 8'h00;
      else if (wen) exp_do[8*b +: 8] = rd[8*b +: 8];
    end

    bus.CE = 1'b1; bus.BCYSTn = 1'b0; bus.RAM_CEn = 1'b0;
    bus.RAM_A = a; bus.RAM_DI = di; bus.RAM_BEn = ben; bus.RAM_WEn = wen;
    ce_prev = 1'b1; in_txn = 1'b0; ack_sent = 1'b0; ready_low = 1'b0; done = 1'b0; dly = 0;
    tick();
    for (cnt = 0; cnt < 400 && !done; cnt++) begin
      if (ack_sent) begin
        chk("req_drop", {31'b0, bus.MEM_REQ}, 32'd0);
        ack_sent = 1'b0; in_txn = 1'b0;
        bus.MEM_ACK = 1'b0;
      end else if (bus.MEM_REQ) begin
        if (!in_txn) begin
          if (exp_q.size() == 0) begin
            chk("extra_req", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            in_txn = 1'b1;
            dly = (ack_dly >= 0) ? ack_dly : int'($urandom_range(0, 3));
            if (abort_hi && cur.hi) begin
              RESn = 1'b0;
              #1;
              check_reset_outputs("rst_mid");
              exp_do = 32'h0;
              bus.MEM_ACK = 1'b1;
              tick();
              bus.MEM_ACK = 1'b0;
              chk("rst_held_req", {31'b0, bus.MEM_REQ}, 32'd0);
              RESn = 1'b1;
              done = 1'b1;
              break;
            end
          end
        end
        if (in_txn) begin
          chk("mem_addr", 32'(bus.MEM_ADDR), 32'(cur.addr));
          chk("mem_be",   32'(bus.MEM_BE),   32'(cur.be));
          chk("mem_we",   {31'b0, bus.MEM_WE}, {31'b0, cur.we});
          chk("mem_din",  32'(bus.MEM_DIN),  32'(cur.din));
          if (dly == 0) begin
            bus.MEM_ACK  = 1'b1;
            bus.MEM_DOUT = cur.hi ? dhi : dlo;
            ack_sent = 1'b1;
          end else begin
            dly--;
          end
        end
      end else begin
        if (in_txn) chk("req_lost", 32'd0, 32'd1);
        bus.MEM_ACK  = noise ? 1'($urandom) : 1'b0;
        bus.MEM_DOUT = 16'($urandom);
      end

      if (ready_low) begin
        if (ce_prev) begin
          chk("ready_one_ce", {31'b0, bus.RAM_READYn}, 32'd1);
          done = 1'b1;
        end else begin
          chk("ready_hold", {31'b0, bus.RAM_READYn}, 32'd0);
        end
      end else if (!bus.RAM_READYn) begin
        ready_low = 1'b1;
        chk("pending_at_ready", 32'(exp_q.size()) + {31'b0, in_txn}, 32'd0);
        chk("ram_do", bus.RAM_DO, exp_do);
      end

      if (!done) begin
        bus.CE  = ((cnt % ce_div) == 0);
        ce_prev = bus.CE;
        if (noise) begin
          bus.BCYSTn  = 1'($urandom);
          bus.RAM_CEn = 1'($urandom);
          bus.RAM_A   = AW'($urandom);
          bus.RAM_DI  = $urandom;
          bus.RAM_BEn = 4'($urandom);
          bus.RAM_WEn = 1'($urandom);
        end else begin
          bus.BCYSTn = 1'b1;
        end
        tick();
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    idle_inputs();
  endtask

  task automatic rom_cycle;
    bus.CE = 1'b1; bus.BCYSTn = 1'b0; bus.RAM_CEn = 1'b1;
    bus.RAM_A = AW'($urandom); bus.RAM_BEn = 4'h0; bus.RAM_WEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rom_req",   {31'b0, bus.MEM_REQ}, 32'd0);
      chk("rom_ready", {31'b0, bus.RAM_READYn}, 32'd1);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    bus.RAM_A = '0; bus.RAM_DI = 32'h0;
    RESn = 1'b0;
    exp_do = 32'h0;
    tick();
    check_reset_outputs("reset");
    tick();
    RESn = 1'b1;
    tick();

    bus_cycle(21'h000104, 32'h0, 4'b0000, 1'b1, 16'h5678, 16'h1234, 1, 0, 1'b0, 1'b0);
    chk("t1_word", bus.RAM_DO, 32'h12345678);

    bus_cycle(21'h000010, 32'h00AB0000, 4'b1011, 1'b0, 16'h1111, 16'h2222, 1, 0, 1'b0, 1'b0);

    bus_cycle(21'h00ABC0, 32'hDEADBEEF, 4'b1111, 1'b1, 16'h3333, 16'h4444, 2, 0, 1'b0, 1'b0);
    chk("t3_do_zero", bus.RAM_DO, 32'h0);

    bus_cycle(21'h1F0008, 32'h0, 4'b0000, 1'b1, 16'hA5C3, 16'h0F1E, 4, 5, 1'b0, 1'b0);

    rom_cycle();
    bus_cycle(21'h012344, 32'h0, 4'b0000, 1'b1, 16'hBEEF, 16'hCAFE, 3, -1, 1'b1, 1'b0);

    bus_cycle(21'h000200, 32'h0, 4'b0000, 1'b1, 16'h9999, 16'h8888, 1, 2, 1'b0, 1'b1);
    bus_cycle(21'h000204, 32'h0, 4'b0000, 1'b1, 16'h7654, 16'h3210, 1, 0, 1'b0, 1'b0);
    chk("t6_after_reset", bus.RAM_DO, 32'h32107654);

    for (int n = 0; n < 40; n++) begin
      bus_cycle(AW'($urandom), $urandom, 4'($urandom), 1'($urandom), 16'($urandom),
                16'($urandom), int'($urandom_range(1, 4)), -1, 1'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
